// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: access modes, RAM read/write
// polarity, controller state encoding and the alignment legality check.
package mem_pkg;

    localparam logic [1:0] BYTE     = 2'b00;
    localparam logic [1:0] HALFWORD = 2'b01;
    localparam logic [1:0] WORD     = 2'b10;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    typedef enum logic [1:0] {IDLE, ACCESS, ERR, DONE} state_t;

    function automatic logic access_illegal(input logic [1:0] mode, input logic [1:0] addr_lo);
        case (mode)
            BYTE:     return 1'b0;
            HALFWORD: return addr_lo[0];
            WORD:     return addr_lo != 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the arbiter; slave is the arbiter's
// view, master is the view of the CPU control unit plus the RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_mode;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              ram_enable;
    logic              ram_w_r;
    logic [1:0]        ram_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_moc;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, ram_moc, ram_rdata,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output ram_enable, ram_w_r, ram_mode, ram_addr, ram_data
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, ram_moc, ram_rdata,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  ram_enable, ram_w_r, ram_mode, ram_addr, ram_data
    );

endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-request round-robin arbiter; the last-grant register only moves when
// the controller is idle and actually grants someone.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic adv,
    output logic gnt_i,
    output logic gnt_d
);
    logic last_d;

    always_comb begin
        gnt_d = adv & req_d & (~req_i | ~last_d);
        gnt_i = adv & req_i & (~req_d | last_d);
    end

    // Reset value makes the data port win the first contended grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (gnt_i || gnt_d) begin
            last_d <= gnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM between the fetch and data ports: arbitrates, sequences the
// level-sensitive RAM enable/w_r/mode/MOC handshake and returns a one-cycle ack.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int READ_WAIT   = 2,
    parameter int MOC_TIMEOUT = 8
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    state_t            state;
    logic [7:0]        cnt;
    logic              sel_d;
    logic              we_q;
    logic              gnt_i;
    logic              gnt_d;
    logic              idle;
    logic              req_we;
    logic [1:0]        req_mode;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              moc_seen;

    assign idle = (state == IDLE);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.if_req),
        .req_d (bus.d_req),
        .adv   (idle),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );

    always_comb begin
        req_we    = gnt_d & bus.d_we;
        req_mode  = gnt_d ? bus.d_mode : WORD;
        req_addr  = gnt_d ? bus.d_addr : bus.if_addr;
        req_wdata = gnt_d ? bus.d_wdata : '0;
        // First ACCESS cycle may still see MOC left over from the previous write.
        moc_seen  = (cnt >= 8'd2) && bus.ram_moc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            sel_d          <= 1'b0;
            we_q           <= 1'b0;
            bus.if_ack     <= 1'b0;
            bus.if_err     <= 1'b0;
            bus.if_rdata   <= '0;
            bus.d_ack      <= 1'b0;
            bus.d_err      <= 1'b0;
            bus.d_rdata    <= '0;
            bus.ram_enable <= 1'b0;
            bus.ram_w_r    <= RAM_READ;
            bus.ram_mode   <= '0;
            bus.ram_addr   <= '0;
            bus.ram_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_i || gnt_d) begin
                        sel_d <= gnt_d;
                        we_q  <= req_we;
                        if (access_illegal(req_mode, req_addr[1:0])) begin
                            state <= ERR;
                            if (gnt_d) begin
                                bus.d_ack   <= 1'b1;
                                bus.d_err   <= 1'b1;
                                bus.d_rdata <= '0;
                            end else begin
                                bus.if_ack   <= 1'b1;
                                bus.if_err   <= 1'b1;
                                bus.if_rdata <= '0;
                            end
                        end else begin
                            state          <= ACCESS;
                            cnt            <= 8'd1;
                            bus.ram_enable <= 1'b1;
                            bus.ram_w_r    <= req_we ? RAM_WRITE : RAM_READ;
                            bus.ram_mode   <= req_mode;
                            bus.ram_addr   <= req_addr;
                            bus.ram_data   <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (!we_q) begin
                        if (cnt == 8'(READ_WAIT + 1)) begin
                            bus.ram_enable <= 1'b0;
                            state          <= DONE;
                            if (sel_d) begin
                                bus.d_ack   <= 1'b1;
                                bus.d_err   <= 1'b0;
                                bus.d_rdata <= bus.ram_rdata;
                            end else begin
                                bus.if_ack   <= 1'b1;
                                bus.if_err   <= 1'b0;
                                bus.if_rdata <= bus.ram_rdata;
                            end
                        end
                    end else if (moc_seen || cnt == 8'(MOC_TIMEOUT)) begin
                        bus.ram_enable <= 1'b0;
                        state          <= DONE;
                        bus.d_ack      <= 1'b1;
                        bus.d_err      <= ~moc_seen;
                        bus.d_rdata    <= '0;
                    end
                end
                ERR, DONE: begin
                    state      <= IDLE;
                    bus.if_ack <= 1'b0;
                    bus.if_err <= 1'b0;
                    bus.d_ack  <= 1'b0;
                    bus.d_err  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural big-endian byte RAM
// whose write MOC timing is programmable per access.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .ADDR_W(8), .DATA_W(32), .READ_WAIT(2), .MOC_TIMEOUT(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // RAM model: moc_at is the enable cycle in which MOC rises on a write (0 = never)
    logic [7:0]  mem [256];
    int          moc_at = 0;
    int          en_edges = 0;
    logic        moc_q = 1'b0;
    logic [31:0] rd_val;
    logic        poke_en = 1'b0;
    logic [7:0]  poke_a = 8'h00;
    logic [31:0] poke_w = 32'h0;

    assign bus.ram_moc   = moc_q;
    assign bus.ram_rdata = rd_val;

    always_comb begin
        rd_val = 32'h0;
        if (bus.ram_enable && bus.ram_w_r) begin
            case (bus.ram_mode)
                BYTE:     rd_val = {24'h0, mem[bus.ram_addr]};
                HALFWORD: rd_val = {16'h0, mem[bus.ram_addr], mem[8'(bus.ram_addr + 8'd1)]};
                default:  rd_val = {mem[bus.ram_addr], mem[8'(bus.ram_addr + 8'd1)],
                                    mem[8'(bus.ram_addr + 8'd2)], mem[8'(bus.ram_addr + 8'd3)]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_a]               = poke_w[31:24];
            mem[8'(poke_a + 8'd1)]    = poke_w[23:16];
            mem[8'(poke_a + 8'd2)]    = poke_w[15:8];
            mem[8'(poke_a + 8'd3)]    = poke_w[7:0];
        end
        if (bus.ram_enable) begin
            en_edges <= en_edges + 1;
            if (!bus.ram_w_r && moc_at != 0 && en_edges + 2 >= moc_at) begin
                moc_q <= 1'b1;
                case (bus.ram_mode)
                    BYTE: mem[bus.ram_addr] = bus.ram_data[7:0];
                    HALFWORD: begin
                        mem[bus.ram_addr]            = bus.ram_data[15:8];
                        mem[8'(bus.ram_addr + 8'd1)] = bus.ram_data[7:0];
                    end
                    default: begin
                        mem[bus.ram_addr]            = bus.ram_data[31:24];
                        mem[8'(bus.ram_addr + 8'd1)] = bus.ram_data[23:16];
                        mem[8'(bus.ram_addr + 8'd2)] = bus.ram_data[15:8];
                        mem[8'(bus.ram_addr + 8'd3)] = bus.ram_data[7:0];
                    end
                endcase
            end else begin
                moc_q <= 1'b0;
            end
        end else begin
            en_edges <= 0;
        end
    end

    task automatic poke_word(input logic [7:0] a, input logic [31:0] w);
        @(negedge clk);
        poke_a  = a;
        poke_w  = w;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issues one request, samples each cycle after the grant edge until the ack.
    task automatic do_access(input bit is_d, input bit we, input logic [1:0] mode,
                             input logic [7:0] addr, input logic [31:0] wd,
                             output int ack_cyc, output int en_first, output int en_last,
                             output int en_cnt, output logic [31:0] rdata,
                             output logic err, output logic stray);
        ack_cyc = -1; en_first = 0; en_last = 0; en_cnt = 0;
        rdata = 32'h0; err = 1'b0; stray = 1'b0;
        @(negedge clk);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_mode = mode; bus.d_addr = addr; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ram_enable) begin
                if (en_cnt == 0) en_first = n;
                en_last = n;
                en_cnt++;
            end
            if (is_d ? bus.if_ack : bus.d_ack) stray = 1'b1;
            if (is_d ? bus.d_ack : bus.if_ack) begin
                ack_cyc = n;
                rdata   = is_d ? bus.d_rdata : bus.if_rdata;
                err     = is_d ? bus.d_err : bus.if_err;
                break;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.ram_enable, bus.ram_w_r, bus.if_ack, bus.d_ack, bus.if_err, bus.d_err} !== 6'b010000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, expected 010000",
                     {bus.ram_enable, bus.ram_w_r, bus.if_ack, bus.d_ack, bus.if_err, bus.d_err});
        end
        tests++;
        if ({bus.if_rdata, bus.d_rdata, bus.ram_data, bus.ram_addr, bus.ram_mode} !== '0) begin
            fails++;
            $display("FAIL reset_data: if_rdata=%h d_rdata=%h ram_data=%h ram_addr=%h ram_mode=%b, expected all 0",
                     bus.if_rdata, bus.d_rdata, bus.ram_data, bus.ram_addr, bus.ram_mode);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.ram_enable !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_enable: got %b, expected 0", bus.ram_enable);
        end
    endtask

    task automatic test_fetch();
        int ac, ef, el, ec; logic [31:0] rd; logic er, st;
        poke_word(8'h08, 32'h11223344);
        do_access(1'b0, 1'b0, WORD, 8'h08, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if ({ac, ef, el, ec} !== {32'd4, 32'd1, 32'd3, 32'd3}) begin
            fails++;
            $display("FAIL fetch_timing: ack=%0d en=%0d..%0d (%0d), expected ack=4 en=1..3 (3)", ac, ef, el, ec);
        end
        tests++;
        if (rd !== 32'h11223344 || er !== 1'b0 || st !== 1'b0) begin
            fails++;
            $display("FAIL fetch_data: rdata=%h err=%b stray=%b, expected 11223344 0 0", rd, er, st);
        end
    endtask

    task automatic test_store_load();
        int ac, ef, el, ec; logic [31:0] rd; logic er, st;
        moc_at = 2;
        do_access(1'b1, 1'b1, WORD, 8'h10, 32'hCAFEBABE, ac, ef, el, ec, rd, er, st);
        tests++;
        if ({ac, ef, el, ec} !== {32'd3, 32'd1, 32'd2, 32'd2} || er !== 1'b0) begin
            fails++;
            $display("FAIL store_word: ack=%0d en=%0d..%0d (%0d) err=%b, expected ack=3 en=1..2 (2) err=0",
                     ac, ef, el, ec, er);
        end
        do_access(1'b1, 1'b0, WORD, 8'h10, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if (rd !== 32'hCAFEBABE || ac !== 4 || er !== 1'b0) begin
            fails++;
            $display("FAIL load_word: rdata=%h ack=%0d err=%b, expected CAFEBABE 4 0", rd, ac, er);
        end
        do_access(1'b1, 1'b0, BYTE, 8'h11, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if (rd !== 32'h000000FE || er !== 1'b0) begin
            fails++;
            $display("FAIL load_byte: rdata=%h err=%b, expected 000000FE 0", rd, er);
        end
        do_access(1'b1, 1'b0, HALFWORD, 8'h12, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if (rd !== 32'h0000BABE || er !== 1'b0) begin
            fails++;
            $display("FAIL load_half: rdata=%h err=%b, expected 0000BABE 0", rd, er);
        end
        poke_word(8'hFC, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, WORD, 8'hFC, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || st !== 1'b0) begin
            fails++;
            $display("FAIL load_word_fc: rdata=%h err=%b stray=%b, expected DEADBEEF 0 0", rd, er, st);
        end
    endtask

    task automatic test_illegal();
        int ac, ef, el, ec; logic [31:0] rd; logic er, st;
        do_access(1'b1, 1'b0, HALFWORD, 8'h03, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if (ac !== 1 || ec !== 0 || er !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL illegal_half: ack=%0d en_cycles=%0d err=%b rdata=%h, expected 1 0 1 00000000",
                     ac, ec, er, rd);
        end
        do_access(1'b1, 1'b1, 2'b11, 8'h10, 32'h12345678, ac, ef, el, ec, rd, er, st);
        tests++;
        if (ac !== 1 || ec !== 0 || er !== 1'b1 || rd !== 32'h0) begin
            fails++;
            $display("FAIL illegal_mode: ack=%0d en_cycles=%0d err=%b rdata=%h, expected 1 0 1 00000000",
                     ac, ec, er, rd);
        end
        do_access(1'b0, 1'b0, WORD, 8'h02, 32'h0, ac, ef, el, ec, rd, er, st);
        tests++;
        if (ac !== 1 || ec !== 0 || er !== 1'b1 || rd !== 32'h0 || st !== 1'b0) begin
            fails++;
            $display("FAIL illegal_fetch: ack=%0d en_cycles=%0d err=%b rdata=%h stray=%b, expected 1 0 1 00000000 0",
                     ac, ec, er, rd, st);
        end
    endtask

    task automatic test_timeout();
        int ac, ef, el, ec; logic [31:0] rd; logic er, st;
        moc_at = 2;
        do_access(1'b1, 1'b1, WORD, 8'h20, 32'h01020304, ac, ef, el, ec, rd, er, st);
        tests++;
        if (ac !== 3 || er !== 1'b0 || bus.ram_moc !== 1'b1) begin
            fails++;
            $display("FAIL timeout_prep: ack=%0d err=%b moc=%b, expected 3 0 1", ac, er, bus.ram_moc);
        end
        moc_at = 0;
        do_access(1'b1, 1'b1, WORD, 8'h24, 32'h0A0B0C0D, ac, ef, el, ec, rd, er, st);
        tests++;
        if ({ac, ef, el, ec} !== {32'd9, 32'd1, 32'd8, 32'd8}) begin
            fails++;
            $display("FAIL timeout_timing: ack=%0d en=%0d..%0d (%0d), expected ack=9 en=1..8 (8)", ac, ef, el, ec);
        end
        tests++;
        if (er !== 1'b1) begin
            fails++;
            $display("FAIL timeout_err: got %b, expected 1", er);
        end
        moc_at = 2;
    endtask

    task automatic test_back_to_back();
        bit seq [4];
        bit exp_seq [4];
        int nack = 0;
        int run = 0, max_run = 0, runs = 0;
        bit overlap = 1'b0;
        bit data_ok = 1'b1;
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        seq     = '{1'b0, 1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 8'h08;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = WORD; bus.d_addr = 8'h10;
        for (int n = 0; n < 60 && nack < 4; n++) begin
            @(negedge clk);
            if (bus.ram_enable) run++;
            else if (run > 0) begin
                runs++;
                if (run > max_run) max_run = run;
                run = 0;
            end
            if (bus.if_ack && bus.d_ack) overlap = 1'b1;
            if (bus.d_ack) begin
                seq[nack] = 1'b1;
                if (bus.d_rdata !== 32'hCAFEBABE) data_ok = 1'b0;
                nack++;
            end else if (bus.if_ack) begin
                seq[nack] = 1'b0;
                if (bus.if_rdata !== 32'h11223344) data_ok = 1'b0;
                nack++;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);
        tests++;
        if (nack !== 4) begin
            fails++;
            $display("FAIL b2b_ack_count: got %0d, expected 4", nack);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (seq[i] !== exp_seq[i]) begin
                fails++;
                $display("FAIL b2b_grant%0d: got %s, expected %s", i, seq[i] ? "D" : "I", exp_seq[i] ? "D" : "I");
            end
        end
        tests++;
        if (overlap !== 1'b0 || runs !== 4 || max_run !== 3 || data_ok !== 1'b1) begin
            fails++;
            $display("FAIL b2b_enable: overlap=%b runs=%0d max_run=%0d data_ok=%b, expected 0 4 3 1",
                     overlap, runs, max_run, data_ok);
        end
    endtask

    task automatic test_reset_mid_read();
        int first = 0;
        bit fetch_done = 1'b0;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 8'h08;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.ram_enable !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_started: enable=%b, expected 1", bus.ram_enable);
        end
        rst_n = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = WORD; bus.d_addr = 8'h10;
        @(negedge clk);
        tests++;
        if ({bus.ram_enable, bus.if_ack, bus.d_ack} !== 3'b000) begin
            fails++;
            $display("FAIL rst_mid_drop: enable/if_ack/d_ack=%b, expected 000",
                     {bus.ram_enable, bus.if_ack, bus.d_ack});
        end
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.d_ack) begin first = 1; break; end
            if (bus.if_ack) begin first = 2; break; end
        end
        tests++;
        if (first !== 1 || bus.d_rdata !== 32'hCAFEBABE) begin
            fails++;
            $display("FAIL rst_mid_first: first=%0d (1=D 2=I 0=none) d_rdata=%h, expected 1 CAFEBABE",
                     first, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                fetch_done = (bus.if_rdata === 32'h11223344);
                break;
            end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        tests++;
        if (fetch_done !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_fetch: got done=%b, expected 1 with 11223344", fetch_done);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = 8'h00;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_mode  = BYTE;
        bus.d_addr  = 8'h00;
        bus.d_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_store_load();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
